edge_pe_req_bus: RTL and testbench

- Request-direction crossbar between the Edge PEs and the FV SRAM bank controllers.
- Each Edge PE issues read requests carrying a global FV address plus sos/eos markers. The block buffers them per PE, decodes the target bank from the low address bits, and arbitrates per bank round-robin.
- It presents one registered request per bank, tagged with the originating PE index. The bank controller returns that tag so read data can be routed back to the correct PE.

---
 rtl/edge_pe_req_bus.sv | 217 +++++++++++++++++++++
 tb/tb_edge_pe_req_bus.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_pe_req_bus.sv
// -----------------------------------------------------------------------------
// edge_pe_req_bus
// Request-direction crossbar from the Edge PEs to the FV SRAM bank controllers.
// Every PE owns a 2-entry request FIFO. The head of each FIFO is decoded to a
// bank from the low address bits. Each bank picks one head round-robin and
// loads it into a registered output stage, tagged with the originating PE
// index so read data can be routed back to that PE.
//
// Ports:
//   clk             : single clock, rising edge
//   reset           : asynchronous active-low reset
//   pe_req_valid    : per-PE request valid
//   pe_req_addr     : per-PE global address, PE i at [i*ADDR_W +: ADDR_W]
//   pe_req_sos/eos  : per-PE start/end-of-stream markers
//   pe_req_ready    : per-PE accept (FIFO not full)
//   bank_req_valid  : per-bank request valid
//   bank_req_addr   : per-bank in-bank address (global addr >> BANK_SEL_W)
//   bank_req_tag    : per-bank originating PE index
//   bank_req_sos/eos: per-bank forwarded markers
//   bank_req_ready  : per-bank accept from the bank controller
// -----------------------------------------------------------------------------
module edge_pe_req_bus #(
    parameter int NUM_EDGE_PE = 4,
    parameter int NUM_BANKS   = 4,
    parameter int ADDR_W      = 10,
    localparam int BANK_SEL_W = $clog2(NUM_BANKS),
    localparam int TAG_W      = (NUM_EDGE_PE > 1) ? $clog2(NUM_EDGE_PE) : 1,
    localparam int LOCAL_W    = ADDR_W - BANK_SEL_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_EDGE_PE-1:0]        pe_req_valid,
    input  logic [NUM_EDGE_PE*ADDR_W-1:0] pe_req_addr,
    input  logic [NUM_EDGE_PE-1:0]        pe_req_sos,
    input  logic [NUM_EDGE_PE-1:0]        pe_req_eos,
    output logic [NUM_EDGE_PE-1:0]        pe_req_ready,
    output logic [NUM_BANKS-1:0]          bank_req_valid,
    output logic [NUM_BANKS*LOCAL_W-1:0]  bank_req_addr,
    output logic [NUM_BANKS*TAG_W-1:0]    bank_req_tag,
    output logic [NUM_BANKS-1:0]          bank_req_sos,
    output logic [NUM_BANKS-1:0]          bank_req_eos,
    input  logic [NUM_BANKS-1:0]          bank_req_ready
);

    // Per-PE FIFO storage and control
    logic [ADDR_W-1:0]      fifo_addr_r [NUM_EDGE_PE][2];
    logic                   fifo_sos_r  [NUM_EDGE_PE][2];
    logic                   fifo_eos_r  [NUM_EDGE_PE][2];
    logic [NUM_EDGE_PE-1:0] wr_ptr_r;
    logic [NUM_EDGE_PE-1:0] rd_ptr_r;
    logic [1:0]             count_r     [NUM_EDGE_PE];

    // Head view of each FIFO
    logic [NUM_EDGE_PE-1:0] ready_s;
    logic [NUM_EDGE_PE-1:0] push_s;
    logic [NUM_EDGE_PE-1:0] pop_s;
    logic [NUM_EDGE_PE-1:0] head_vld_s;
    logic [NUM_EDGE_PE-1:0] head_sos_s;
    logic [NUM_EDGE_PE-1:0] head_eos_s;
    logic [ADDR_W-1:0]      head_addr_s [NUM_EDGE_PE];
    logic [BANK_SEL_W-1:0]  head_bank_s [NUM_EDGE_PE];

    // Per-bank arbitration
    logic [TAG_W-1:0]       rr_ptr_r    [NUM_BANKS];
    logic [TAG_W-1:0]       rr_nxt_s    [NUM_BANKS];
    logic [TAG_W-1:0]       gnt_pe_s    [NUM_BANKS];
    logic [NUM_BANKS-1:0]   gnt_s;
    logic [NUM_BANKS-1:0]   loadable_s;

    // Per-bank output registers
    logic [NUM_BANKS-1:0]   bank_vld_r;
    logic [LOCAL_W-1:0]     bank_addr_r [NUM_BANKS];
    logic [TAG_W-1:0]       bank_tag_r  [NUM_BANKS];
    logic [NUM_BANKS-1:0]   bank_sos_r;
    logic [NUM_BANKS-1:0]   bank_eos_r;

    // Ready depends only on the registered count: a full FIFO stays not-ready
    // even in a cycle where its head is popped.
    always_comb begin
        for (int i = 0; i < NUM_EDGE_PE; i++) begin
            ready_s[i]     = (count_r[i] < 2'd2);
            push_s[i]      = pe_req_valid[i] & ready_s[i];
            head_vld_s[i]  = (count_r[i] != 2'd0);
            head_addr_s[i] = fifo_addr_r[i][rd_ptr_r[i]];
            head_sos_s[i]  = fifo_sos_r[i][rd_ptr_r[i]];
            head_eos_s[i]  = fifo_eos_r[i][rd_ptr_r[i]];
            head_bank_s[i] = head_addr_s[i][BANK_SEL_W-1:0];
        end
    end

    assign pe_req_ready = ready_s;

    // Round-robin pick per bank: first head targeting the bank at or after
    // rr_ptr, wrapping. A PE has one head so it can win at most one bank.
    always_comb begin
        int                 sum_v;
        logic [TAG_W-1:0]   cand_v;
        sum_v  = 0;
        cand_v = '0;
        gnt_s  = '0;
        pop_s  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt_pe_s[b]   = '0;
            rr_nxt_s[b]   = rr_ptr_r[b];
            loadable_s[b] = ~bank_vld_r[b] | bank_req_ready[b];
            for (int o = 0; o < NUM_EDGE_PE; o++) begin
                sum_v = int'(rr_ptr_r[b]) + o;
                if (sum_v >= NUM_EDGE_PE) begin
                    sum_v = sum_v - NUM_EDGE_PE;
                end else begin
                    sum_v = sum_v;
                end
                cand_v = TAG_W'(sum_v);
                if (!gnt_s[b] && loadable_s[b] && head_vld_s[cand_v] &&
                    (head_bank_s[cand_v] == BANK_SEL_W'(b))) begin
                    gnt_s[b]    = 1'b1;
                    gnt_pe_s[b] = cand_v;
                end else begin
                    gnt_s[b]    = gnt_s[b];
                end
            end
            sum_v = int'(gnt_pe_s[b]) + 1;
            if (sum_v >= NUM_EDGE_PE) begin
                sum_v = 0;
            end else begin
                sum_v = sum_v;
            end
            if (gnt_s[b]) begin
                rr_nxt_s[b] = TAG_W'(sum_v);
            end else begin
                rr_nxt_s[b] = rr_ptr_r[b];
            end
        end
        for (int k = 0; k < NUM_EDGE_PE; k++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (gnt_s[b] && (gnt_pe_s[b] == TAG_W'(k))) begin
                    pop_s[k] = 1'b1;
                end else begin
                    pop_s[k] = pop_s[k];
                end
            end
        end
    end

    // Per-PE FIFO pointers, count and storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < NUM_EDGE_PE; i++) begin
                count_r[i] <= 2'd0;
                for (int e = 0; e < 2; e++) begin
                    fifo_addr_r[i][e] <= '0;
                    fifo_sos_r[i][e]  <= 1'b0;
                    fifo_eos_r[i][e]  <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_EDGE_PE; i++) begin
                if (push_s[i]) begin
                    fifo_addr_r[i][wr_ptr_r[i]] <= pe_req_addr[i*ADDR_W +: ADDR_W];
                    fifo_sos_r[i][wr_ptr_r[i]]  <= pe_req_sos[i];
                    fifo_eos_r[i][wr_ptr_r[i]]  <= pe_req_eos[i];
                    wr_ptr_r[i]                 <= ~wr_ptr_r[i];
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= ~rd_ptr_r[i];
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + 2'd1;
                    2'b01:   count_r[i] <= count_r[i] - 2'd1;
                    default: count_r[i] <= count_r[i];
                endcase
            end
        end
    end

    // Bank output registers and round-robin pointers; a stalled bank holds
    // every field unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_vld_r <= '0;
            bank_sos_r <= '0;
            bank_eos_r <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_addr_r[b] <= '0;
                bank_tag_r[b]  <= '0;
                rr_ptr_r[b]    <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr_r[b] <= rr_nxt_s[b];
                if (gnt_s[b]) begin
                    bank_vld_r[b]  <= 1'b1;
                    bank_addr_r[b] <= head_addr_s[gnt_pe_s[b]][ADDR_W-1:BANK_SEL_W];
                    bank_tag_r[b]  <= gnt_pe_s[b];
                    bank_sos_r[b]  <= head_sos_s[gnt_pe_s[b]];
                    bank_eos_r[b]  <= head_eos_s[gnt_pe_s[b]];
                end else if (loadable_s[b]) begin
                    bank_vld_r[b]  <= 1'b0;
                end else begin
                    bank_vld_r[b]  <= bank_vld_r[b];
                end
            end
        end
    end

    assign bank_req_valid = bank_vld_r;
    assign bank_req_sos   = bank_sos_r;
    assign bank_req_eos   = bank_eos_r;

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank_out
        assign bank_req_addr[gb*LOCAL_W +: LOCAL_W] = bank_addr_r[gb];
        assign bank_req_tag[gb*TAG_W +: TAG_W]      = bank_tag_r[gb];
    end

endmodule

// File: tb/tb_edge_pe_req_bus.sv
// -----------------------------------------------------------------------------
// tb_edge_pe_req_bus
// Directed bench for edge_pe_req_bus. Stimulus pushes the expected bank
// transfers into per-bank queues; a monitor on the falling edge pops and
// compares whenever a bank handshake (valid & ready) is presented. Directed
// cycle checks cover latency, hold, ready and reset behaviour.
// -----------------------------------------------------------------------------
module tb_edge_pe_req_bus;

    localparam int NP = 4;
    localparam int NB = 4;
    localparam int AW = 10;
    localparam int LW = 8;
    localparam int TW = 2;

    logic             clk;
    logic             reset;
    logic [NP-1:0]    pe_req_valid;
    logic [NP*AW-1:0] pe_req_addr;
    logic [NP-1:0]    pe_req_sos;
    logic [NP-1:0]    pe_req_eos;
    logic [NP-1:0]    pe_req_ready;
    logic [NB-1:0]    bank_req_valid;
    logic [NB*LW-1:0] bank_req_addr;
    logic [NB*TW-1:0] bank_req_tag;
    logic [NB-1:0]    bank_req_sos;
    logic [NB-1:0]    bank_req_eos;
    logic [NB-1:0]    bank_req_ready;

    typedef struct packed {
        logic [LW-1:0] addr;
        logic [TW-1:0] tag;
        logic          sos;
        logic          eos;
    } exp_t;

    exp_t exp_q [NB][$];
    int   checks;
    int   errors;
    int   sent;
    logic rdy_v;
    logic [AW-1:0] stream [4];

    edge_pe_req_bus #(
        .NUM_EDGE_PE (NP),
        .NUM_BANKS   (NB),
        .ADDR_W      (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pe_req_valid   (pe_req_valid),
        .pe_req_addr    (pe_req_addr),
        .pe_req_sos     (pe_req_sos),
        .pe_req_eos     (pe_req_eos),
        .pe_req_ready   (pe_req_ready),
        .bank_req_valid (bank_req_valid),
        .bank_req_addr  (bank_req_addr),
        .bank_req_tag   (bank_req_tag),
        .bank_req_sos   (bank_req_sos),
        .bank_req_eos   (bank_req_eos),
        .bank_req_ready (bank_req_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] baddr(input int b);
        return 32'(bank_req_addr[b*LW +: LW]);
    endfunction

    function automatic logic [31:0] btag(input int b);
        return 32'(bank_req_tag[b*TW +: TW]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int pe, input logic [AW-1:0] a, input logic s, input logic e);
        pe_req_valid[pe]         = 1'b1;
        pe_req_addr[pe*AW +: AW] = a;
        pe_req_sos[pe]           = s;
        pe_req_eos[pe]           = e;
    endtask

    task automatic clear_req();
        pe_req_valid = '0;
        pe_req_sos   = '0;
        pe_req_eos   = '0;
    endtask

    task automatic expect_req(input int b, input logic [LW-1:0] a, input int tag,
                              input logic s, input logic e);
        exp_t x;
        x.addr = a;
        x.tag  = TW'(tag);
        x.sos  = s;
        x.eos  = e;
        exp_q[b].push_back(x);
    endtask

    // Scoreboard monitor: every bank handshake must match the next expected entry
    always @(negedge clk) begin
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                if (bank_req_valid[b] && bank_req_ready[b]) begin
                    if (exp_q[b].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected bank=%0d actual tag=%0d addr=0x%0h required=none",
                                 b, btag(b), baddr(b));
                    end else begin
                        exp_t e;
                        e = exp_q[b].pop_front();
                        check($sformatf("sb_addr_b%0d", b), baddr(b), 32'(e.addr));
                        check($sformatf("sb_tag_b%0d", b), btag(b), 32'(e.tag));
                        check($sformatf("sb_sos_b%0d", b), 32'(bank_req_sos[b]), 32'(e.sos));
                        check($sformatf("sb_eos_b%0d", b), 32'(bank_req_eos[b]), 32'(e.eos));
                    end
                end
            end
        end
    end

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b0;
        pe_req_valid   = '0;
        pe_req_addr    = '0;
        pe_req_sos     = '0;
        pe_req_eos     = '0;
        bank_req_ready = 4'b1111;
        stream[0] = 10'h000;
        stream[1] = 10'h004;
        stream[2] = 10'h008;
        stream[3] = 10'h00C;

        // Reset state
        #1;
        check("rst_valid", 32'(bank_req_valid), 32'h0);
        check("rst_ready", 32'(pe_req_ready), 32'hF);
        check("rst_addr", 32'(bank_req_addr), 32'h0);
        check("rst_tag", 32'(bank_req_tag), 32'h0);
        step();
        step();
        reset = 1'b1;
        step();

        // 1. Single request PE2 -> bank 1, local 0x035
        expect_req(1, 8'h35, 2, 1'b1, 1'b0);
        drive(2, 10'h0D5, 1'b1, 1'b0);
        step();
        clear_req();
        check("t1_no_early", 32'(bank_req_valid), 32'h0);
        step();
        check("t1_valid", 32'(bank_req_valid), 32'h2);
        check("t1_addr", baddr(1), 32'h035);
        check("t1_tag", btag(1), 32'd2);
        check("t1_sos", 32'(bank_req_sos[1]), 32'd1);
        check("t1_eos", 32'(bank_req_eos[1]), 32'd0);
        step();
        check("t1_gone", 32'(bank_req_valid), 32'h0);

        // 2. Contention on bank 3, two waves
        for (int w = 0; w < 2; w++) begin
            for (int p = 0; p < NP; p++) begin
                drive(p, 10'h003, 1'b0, 1'b0);
                expect_req(3, 8'h00, p, 1'b0, 1'b0);
            end
            step();
            clear_req();
            for (int k = 0; k < NP; k++) begin
                step();
                check($sformatf("t2_w%0d_valid%0d", w, k), 32'(bank_req_valid), 32'h8);
                check($sformatf("t2_w%0d_tag%0d", w, k), btag(3), 32'(k));
            end
        end
        step();
        check("t2_drain", 32'(bank_req_valid), 32'h0);

        // 3. Parallel banks
        for (int p = 0; p < NP; p++) begin
            drive(p, AW'(10'h100 + p), 1'b0, 1'b0);
            expect_req(p, 8'h40, p, 1'b0, 1'b0);
        end
        step();
        clear_req();
        step();
        check("t3_valid", 32'(bank_req_valid), 32'hF);
        for (int b = 0; b < NB; b++) begin
            check($sformatf("t3_tag_b%0d", b), btag(b), 32'(b));
            check($sformatf("t3_addr_b%0d", b), baddr(b), 32'h040);
        end
        step();
        check("t3_drain", 32'(bank_req_valid), 32'h0);

        // 4. Backpressure on bank 0 while PE1 streams
        bank_req_ready = 4'b1110;
        for (int q = 0; q < 4; q++) expect_req(0, LW'(q), 1, 1'b0, 1'b0);
        sent = 0;
        drive(1, stream[0], 1'b0, 1'b0);
        for (int s = 1; s <= 6; s++) begin
            rdy_v = pe_req_ready[1];
            step();
            if (rdy_v) sent++;
            if (sent < 4) drive(1, stream[sent], 1'b0, 1'b0);
            else clear_req();
            check($sformatf("t4_pe_ready_s%0d", s), 32'(pe_req_ready[1]), (s >= 3) ? 32'd0 : 32'd1);
            if (s >= 2) begin
                check($sformatf("t4_hold_valid_s%0d", s), 32'(bank_req_valid[0]), 32'd1);
                check($sformatf("t4_hold_addr_s%0d", s), baddr(0), 32'h000);
                check($sformatf("t4_hold_tag_s%0d", s), btag(0), 32'd1);
            end
        end
        check("t4_accepts_in_stall", 32'(sent), 32'd3);
        bank_req_ready = 4'b1111;
        for (int g = 0; g < 20 && sent < 4; g++) begin
            rdy_v = pe_req_ready[1];
            step();
            if (rdy_v) sent++;
            if (sent < 4) drive(1, stream[sent], 1'b0, 1'b0);
            else clear_req();
        end
        clear_req();
        check("t4_all_sent", 32'(sent), 32'd4);
        for (int d = 0; d < 4; d++) step();
        check("t4_drain", 32'(bank_req_valid), 32'h0);
        check("t4_sb_empty", 32'(exp_q[0].size()), 32'd0);

        // 5. Head-of-line blocking: bank 2 occupied by PE1, PE0 head waits
        bank_req_ready = 4'b1011;
        expect_req(2, 8'h01, 1, 1'b0, 1'b0);
        expect_req(2, 8'h00, 0, 1'b0, 1'b0);
        expect_req(0, 8'h00, 0, 1'b0, 1'b0);
        drive(1, 10'h006, 1'b0, 1'b0);
        step();
        clear_req();
        drive(0, 10'h002, 1'b0, 1'b0);
        step();
        clear_req();
        drive(0, 10'h000, 1'b0, 1'b0);
        step();
        clear_req();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t5_b0_idle%0d", k), 32'(bank_req_valid[0]), 32'd0);
            check($sformatf("t5_b2_tag%0d", k), btag(2), 32'd1);
            step();
        end
        bank_req_ready = 4'b1111;
        step();
        check("t5_b0_still_idle", 32'(bank_req_valid[0]), 32'd0);
        check("t5_b2_pe0", btag(2), 32'd0);
        step();
        check("t5_b0_valid", 32'(bank_req_valid[0]), 32'd1);
        check("t5_b0_tag", btag(0), 32'd0);
        check("t5_b2_done", 32'(bank_req_valid[2]), 32'd0);
        step();
        check("t5_drain", 32'(bank_req_valid), 32'h0);

        // 6. Reset mid-stream with full FIFOs and all banks valid
        bank_req_ready = 4'b0000;
        for (int p = 0; p < NP; p++) drive(p, AW'(p), 1'b0, 1'b0);
        step();
        clear_req();
        drive(0, 10'h004, 1'b0, 1'b0);
        drive(1, 10'h005, 1'b0, 1'b0);
        step();
        clear_req();
        drive(0, 10'h008, 1'b0, 1'b0);
        drive(1, 10'h009, 1'b0, 1'b0);
        step();
        clear_req();
        check("t6_full_ready", 32'(pe_req_ready), 32'hC);
        check("t6_all_valid", 32'(bank_req_valid), 32'hF);
        reset = 1'b0;
        #2;
        check("t6_async_valid", 32'(bank_req_valid), 32'h0);
        check("t6_async_ready", 32'(pe_req_ready), 32'hF);
        check("t6_async_tag", 32'(bank_req_tag), 32'h0);
        step();
        step();
        reset = 1'b1;
        bank_req_ready = 4'b1111;
        expect_req(0, 8'h00, 3, 1'b0, 1'b1);
        drive(3, 10'h000, 1'b0, 1'b1);
        step();
        clear_req();
        check("t6_no_stale", 32'(bank_req_valid), 32'h0);
        step();
        check("t6_fresh_valid", 32'(bank_req_valid), 32'h1);
        check("t6_fresh_tag", btag(0), 32'd3);
        check("t6_fresh_eos", 32'(bank_req_eos[0]), 32'd1);
        step();
        check("t6_drain", 32'(bank_req_valid), 32'h0);
        step();
        step();
        check("t6_final_valid", 32'(bank_req_valid), 32'h0);

        for (int b = 0; b < NB; b++) begin
            check($sformatf("sb_left_b%0d", b), 32'(exp_q[b].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
